alu_wb_stage: RTL
=================

# alu_wb_stage

Writeback and flags stage directly downstream of the 16-bit subtract/xor/pass ALU slice in NARC. It captures each ALU result with its destination register number, maintains the Z/N/C condition flags, and feeds the latched borrow back to the ALU `C_IN` pin so that multi-word subtracts chain. Results go to the register-file write port through a two-entry elastic buffer with a valid/ready handshake, so a stalled write port never loses an ALU result.

## Interface
- `W`, 16, datapath width; must match the ALU slice.
- `DW`, 4, destination register number width.
- `CLK`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IN_VALID`  in  1  ALU result presented this cycle.
- `IN_READY`  out  1  stage can accept; a transfer happens when `IN_VALID & IN_READY`.
- `ALU_OUT`  in  W  ALU `OUT`.
- `ALU_C_OUT`  in  1  ALU `C_OUT`, which is the borrow of A - B - C_IN and is 0 for non-subtract functions.
- `FUNC`  in  2  function code the ALU used: 00 subtract, 01 xor, 1x pass.
- `DST`  in  DW  destination register number.
- `FLAG_WE`  in  1  this result updates the flags.
- `CHAIN`  in  1  this operation is a continuation word of a multi-word subtract.
- `C_IN`  out  1  to ALU `C_IN`: `CHAIN & FLAGS[0]`, purely combinational.
- `WB_VALID`  out  1  writeback entry available.
- `WB_READY`  in  1  register file accepts the entry.
- `WB_DATA`  out  W  result to write.
- `WB_DST`  out  DW  register to write.
- `FLAGS`  out  3  {Z, N, C}, with C at bit 0.

## Operation
- Storage is an output register (head) plus one skid register. A 2-bit occupancy state tracks them: EMPTY (0), ONE (1), FULL (2).
- `IN_READY` = `~RST & (state != FULL)`. It is driven from the registered state only and never depends on `WB_READY` combinationally.
- `WB_VALID` = `(state != EMPTY)`. `WB_DATA` and `WB_DST` always show the head entry.
- State transitions, with `push` = input transfer and `pop` = `WB_VALID & WB_READY`:
  - EMPTY: push goes to ONE, and the input loads the head.
  - ONE:
    - push without pop goes to FULL, and the input loads the skid.
    - push with pop stays ONE, and the input loads the head.
    - pop alone goes to EMPTY.
  - FULL:
    - pop goes to ONE, and the skid moves to the head.
    - push is impossible because `IN_READY` is 0.
- Order is strictly FIFO. An entry is never duplicated or dropped except by reset.
- Flags update in the cycle of the push, not the cycle of the pop. They update only when `FLAG_WE` is 1:
  - C gets `ALU_C_OUT`. For FUNC != 00 this is 0.
  - N gets `ALU_OUT[W-1]`.
  - Z gets `(ALU_OUT == 0)` when `CHAIN`=0, and `Z & (ALU_OUT == 0)` when `CHAIN`=1. This makes Z valid for the whole multi-word value.
- A push with `FLAG_WE`=0 leaves the flags unchanged. No flag update happens without a push.
- Because C updates at the push, `C_IN` for a chained word is correct in the very next cycle, so chained words can be pushed back-to-back.
- `CHAIN`=1 with FUNC != 00 is legal: `C_IN` is still driven, and the ALU ignores it.

## Timing
- Reset is asynchronous:
  - state becomes EMPTY, the head and skid registers become 0, and FLAGS becomes 3'b000.
  - `WB_VALID`=0, `WB_DATA`=0, `WB_DST`=0, `C_IN`=0 and `IN_READY`=0 while `RST` is high.
- `IN_READY`=1 in the first cycle after `RST` falls.
- Reset asserted mid-operation, including in state FULL, discards all entries immediately; nothing is written back.
- Latency from push to `WB_VALID` is 1 cycle when the stage was empty, or when it was ONE and popping that same cycle.
- Sustained throughput is one result per cycle while `WB_READY`=1.
- `WB_DATA` and `WB_DST` are stable while `WB_VALID`=1 and `WB_READY`=0.
- FLAGS and `C_IN` reflect a push from the rising edge that accepts it.

## Test plan
- Reset: hold `RST`=1 for 3 cycles with `IN_VALID`=1 → `IN_READY`=0, `WB_VALID`=0, FLAGS=000, `C_IN`=0; one cycle after release `IN_READY`=1.
- Single subtract: push `ALU_OUT`=0x0002, `ALU_C_OUT`=0, `DST`=3, `FLAG_WE`=1, with `WB_READY`=1 → next cycle `WB_VALID`=1, `WB_DATA`=0x0002, `WB_DST`=3, FLAGS=000; the cycle after, `WB_VALID`=0.
- 32-bit chain (0x0001_0000 - 0x0000_0001):
  - Push the low word, 0xFFFF with C_OUT=1 → FLAGS=011 and `C_IN`=1 once `CHAIN`=1 is presented.
  - Push the high word with `CHAIN`=1, 0x0000 with C_OUT=0 → FLAGS=000 (Z=0 because the low word was nonzero).
  - Repeat with low word 0x0000 and high word 0x0000 → FLAGS=100.
- Backpressure: hold `WB_READY`=0 and offer 0x1111, 0x2222, 0x3333 on consecutive cycles → the first two are accepted, `IN_READY`=0 from the cycle after the second push, and 0x3333 is held. Then raise `WB_READY` → writeback order is 0x1111, 0x2222, 0x3333 with no gaps after 0x3333 is accepted.
- Reset in FULL: fill with 0xAAAA and 0xBBBB (FLAGS=010), assert `RST` mid-cycle → `WB_VALID` and FLAGS clear without waiting for a clock edge; neither entry is ever written back.
- Flag gating: push 0x8000 with FUNC=01 and `FLAG_WE`=1 → FLAGS=010 (C cleared). Then push 0x0000 with `FLAG_WE`=0 → FLAGS stays 010 while `WB_DATA`=0x0000 is written back.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: writeback/flags stage behind the 16-bit ALU slice.
// Two-entry elastic buffer (head + skid) toward the register file, Z/N/C flags, borrow feedback.
`default_nettype none

module alu_wb_stage #(
   parameter int W  = 16,
   parameter int DW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [W-1:0]  ALU_OUT,
   input  logic          ALU_C_OUT,
   input  logic [1:0]    FUNC,
   input  logic [DW-1:0] DST,
   input  logic          FLAG_WE,
   input  logic          CHAIN,
   output logic          C_IN,
   output logic          WB_VALID,
   input  logic          WB_READY,
   output logic [W-1:0]  WB_DATA,
   output logic [DW-1:0] WB_DST,
   output logic [2:0]    FLAGS
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  head_data_q, head_data_d;
   logic [DW-1:0] head_dst_q, head_dst_d;
   logic [W-1:0]  skid_data_q, skid_data_d;
   logic [DW-1:0] skid_dst_q, skid_dst_d;
   logic [2:0]    flags_q, flags_d;

   logic push;
   logic pop;
   logic res_zero;

   // Ready comes only from registered state so the write port never sees a comb path back.
   assign IN_READY = ~RST & (state_q != S_FULL);
   assign WB_VALID = (state_q != S_EMPTY);
   assign WB_DATA  = head_data_q;
   assign WB_DST   = head_dst_q;
   assign FLAGS    = flags_q;
   assign C_IN     = CHAIN & flags_q[0];

   assign push     = IN_VALID & IN_READY;
   assign pop      = WB_VALID & WB_READY;
   assign res_zero = (ALU_OUT == '0);

   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_dst_d  = head_dst_q;
      skid_data_d = skid_data_q;
      skid_dst_d  = skid_dst_q;
      case (state_q)
         S_EMPTY: begin
            if (push) begin
               state_d     = S_ONE;
               head_data_d = ALU_OUT;
               head_dst_d  = DST;
            end
         end
         S_ONE: begin
            if (push && !pop) begin
               state_d     = S_FULL;
               skid_data_d = ALU_OUT;
               skid_dst_d  = DST;
            end else if (push && pop) begin
               head_data_d = ALU_OUT;
               head_dst_d  = DST;
            end else if (pop) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (pop) begin
               state_d     = S_ONE;
               head_data_d = skid_data_q;
               head_dst_d  = skid_dst_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Z accumulates across chained words so it describes the whole multi-word result.
   always_comb begin
      flags_d = flags_q;
      if (push && FLAG_WE) begin
         flags_d[2] = CHAIN ? (flags_q[2] & res_zero) : res_zero;
         flags_d[1] = ALU_OUT[W-1];
         flags_d[0] = ALU_C_OUT & (FUNC == 2'b00);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_EMPTY;
         head_data_q <= '0;
         head_dst_q  <= '0;
         skid_data_q <= '0;
         skid_dst_q  <= '0;
         flags_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_dst_q  <= head_dst_d;
         skid_data_q <= skid_data_d;
         skid_dst_q  <= skid_dst_d;
         flags_q     <= flags_d;
      end
   end

endmodule

`default_nettype wire
